// File: rtl/mse_result_reader.sv
// mse_result_reader
//   Reader side of the error-accumulator result interface. Each 64-bit result
//   strobe is captured into a small FIFO and then streamed to the host as two
//   32-bit words over a valid/ready handshake, low word first.
//
//   Ports:
//     clk, rst            clock and synchronous active-high reset
//     data_in/data_valid  64-bit result and its 1-cycle strobe (no back-pressure)
//     m_data/m_valid/m_ready/m_last
//                         32-bit output stream; m_last marks the high word
//     fifo_count          entries currently stored in the FIFO
//     overflow/clear_ovf  sticky drop flag and its clear (set wins)
//     result_cnt          count of results accepted into the FIFO (wraps)
module mse_result_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [63:0]                   data_in,
  input  logic                          data_valid,
  output logic [31:0]                   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_ovf,
  output logic [CNT_W-1:0]              result_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  state_t      state;
  logic [63:0] mem [FIFO_DEPTH];
  logic [63:0] hold;
  logic [AW-1:0] wptr, rptr;
  logic [63:0] head;
  logic        not_empty;
  logic        pop;
  logic        push;

  assign head      = mem[rptr];
  assign not_empty = (fifo_count != '0);

  // A pop happens when the FSM refills its hold register: from IDLE, or at the
  // high-word handshake so the next result follows without a bubble.
  always_comb begin
    pop = 1'b0;
    if (not_empty) begin
      if (state == IDLE)
        pop = 1'b1;
      else if (state == SEND_HI && m_ready)
        pop = 1'b1;
    end
    // A full FIFO still accepts a result when an entry leaves in the same cycle.
    push = data_valid && ((fifo_count < DEPTH_C) || pop);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      result_cnt <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
    end else begin
      if (push) begin
        wptr       <= wptr + AW'(1);
        result_cnt <= result_cnt + CNT_W'(1);
      end
      if (pop)
        rptr <= rptr + AW'(1);

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (data_valid && !push)
        overflow <= 1'b1;
      else if (clear_ovf)
        overflow <= 1'b0;

      // Outputs are registered alongside the state so they change on the same
      // edge as the transition that produces them.
      case (state)
        IDLE: begin
          if (pop) begin
            hold    <= head;
            m_data  <= head[31:0];
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            state   <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (m_ready) begin
            m_data <= hold[63:32];
            m_last <= 1'b1;
            state  <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (m_ready) begin
            if (pop) begin
              hold    <= head;
              m_data  <= head[31:0];
              m_valid <= 1'b1;
              m_last  <= 1'b0;
              state   <= SEND_LO;
            end else begin
              m_data  <= '0;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          m_data  <= '0;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mse_result_reader.sv
module tb_mse_result_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_in;
  logic        data_valid;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        clear_ovf;
  logic [15:0] result_cnt;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected output words: {m_last, m_data}
  logic [32:0] sb [$];

  mse_result_reader #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .fifo_count(fifo_count), .overflow(overflow), .clear_ovf(clear_ovf),
    .result_cnt(result_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input logic [63:0] d);
    sb.push_back({1'b0, d[31:0]});
    sb.push_back({1'b1, d[63:32]});
  endtask

  // Output monitor: sample midway between active edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", {31'd0, m_last, m_data}, 64'h0);
          if (m_data == 32'h0 && !m_last) begin
            errors++;
            $display("FAIL unexpected_word: got zero word, expected none");
          end
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          check("stream_word", {31'd0, m_last, m_data}, {31'd0, e});
        end
      end
      if (!m_valid)
        check("idle_data_zero", {32'd0, m_data}, 64'h0);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    data_valid = 1'b0;
    clear_ovf = 1'b0;
    m_ready = 1'b0;
    sb.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    m_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || m_valid) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words pending, expected 0", name, sb.size());
    end
    check({name, "_count"}, {61'd0, fifo_count}, 64'd0);
  endtask

  typedef struct {
    logic [63:0] data;
    int          stall;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{64'hDEAD_BEEF_CAFE_F00D, 0, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    vecs[1] = '{64'h0000_0000_FFFF_FFFF, 3, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2] = '{64'hFFFF_FFFF_0000_0001, 1, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 7, 32'h9ABC_DEF0, 32'h1234_5678};

    data_in = '0;
    data_valid = 1'b0;
    clear_ovf = 1'b0;
    m_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_data", {32'd0, m_data}, 64'd0);
    check("rst_m_last", {63'd0, m_last}, 64'd0);
    check("rst_count", {61'd0, fifo_count}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_result_cnt", {48'd0, result_cnt}, 64'd0);
    rst = 1'b0;

    // Single result, latency
    m_ready = 1'b1;
    expect_result(64'h0123_4567_89AB_CDEF);
    data_in = 64'h0123_4567_89AB_CDEF;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("t1_count_stored", {61'd0, fifo_count}, 64'd1);
    check("t1_valid_early", {63'd0, m_valid}, 64'd0);
    tick();
    check("t1_lo_valid", {63'd0, m_valid}, 64'd1);
    check("t1_lo_data", {32'd0, m_data}, 64'h89AB_CDEF);
    check("t1_lo_last", {63'd0, m_last}, 64'd0);
    tick();
    check("t1_hi_data", {32'd0, m_data}, 64'h0123_4567);
    check("t1_hi_last", {63'd0, m_last}, 64'd1);
    tick();
    check("t1_done_valid", {63'd0, m_valid}, 64'd0);
    check("t1_done_count", {61'd0, fifo_count}, 64'd0);

    // Table-driven results with varying consumer stalls
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb.push_back({1'b0, vecs[i].exp_lo});
      sb.push_back({1'b1, vecs[i].exp_hi});
      m_ready = 1'b0;
      data_in = vecs[i].data;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      for (int s = 0; s < vecs[i].stall; s++) tick();
      drain("vec");
      check("vec_result_cnt", {48'd0, result_cnt}, 64'(i + 1));
    end

    // Stall during low word
    do_reset();
    expect_result(64'hAAAA_5555_1357_2468);
    data_in = 64'hAAAA_5555_1357_2468;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    for (int s = 0; s < 5; s++) begin
      check("t2_hold_valid", {63'd0, m_valid}, 64'd1);
      check("t2_hold_data", {32'd0, m_data}, 64'h1357_2468);
      tick();
    end
    drain("t2");

    // Overflow with six strobes while stalled
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) expect_result(64'(i));
      data_in = 64'(i);
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    check("t3_overflow", {63'd0, overflow}, 64'd1);
    check("t3_result_cnt", {48'd0, result_cnt}, 64'd5);
    check("t3_count", {61'd0, fifo_count}, 64'd4);
    drain("t3");

    // Full FIFO, push coincident with high-word pop
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      expect_result(64'(i) << 32 | 64'(i + 16));
      data_in = 64'(i) << 32 | 64'(i + 16);
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    check("t4_full", {61'd0, fifo_count}, 64'd4);
    m_ready = 1'b1;
    tick();
    expect_result(64'h6666_0000_0000_6666);
    data_in = 64'h6666_0000_0000_6666;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("t4_count", {61'd0, fifo_count}, 64'd4);
    check("t4_overflow", {63'd0, overflow}, 64'd0);
    check("t4_result_cnt", {48'd0, result_cnt}, 64'd6);
    drain("t4");

    // Reset during high word with entries queued
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      expect_result(64'(i) * 64'h0101_0101_0101_0101);
      data_in = 64'(i) * 64'h0101_0101_0101_0101;
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    check("t5_in_hi", {63'd0, m_last}, 64'd1);
    check("t5_queued", {61'd0, fifo_count}, 64'd3);
    m_ready = 1'b0;
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    check("t5_valid", {63'd0, m_valid}, 64'd0);
    check("t5_count", {61'd0, fifo_count}, 64'd0);
    check("t5_overflow", {63'd0, overflow}, 64'd0);
    check("t5_result_cnt", {48'd0, result_cnt}, 64'd0);
    m_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      tick();
      check("t5_no_stale", {63'd0, m_valid}, 64'd0);
    end

    // clear_ovf against a simultaneous drop
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      expect_result(64'(i + 100));
      data_in = 64'(i + 100);
      data_valid = 1'b1;
      tick();
    end
    data_in = 64'd999;
    clear_ovf = 1'b1;
    tick();
    data_valid = 1'b0;
    check("t6_set_wins", {63'd0, overflow}, 64'd1);
    tick();
    clear_ovf = 1'b0;
    check("t6_cleared", {63'd0, overflow}, 64'd0);
    drain("t6");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish");
    $fatal(1);
  end

endmodule
